// File: rtl/mcs4_rom_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mcs4_rom_bus_ctrl_if
//   CPU-side bus bundle of the MCS-4 ROM slot controller: the shared 4-bit
//   DATA bus, SYNC_N and CM_ROM_N.
//
//   sync_n    CPU sync, low during X3 of every instruction cycle
//   data_i    4-bit bus data driven by the CPU
//   cm_rom_n  ROM command line from the CPU, active-low
//   data_o    4-bit bus data driven back by the ROM slot
//   data_oe   data_o valid / bus drive enable
//
//   modport master : the CPU side (drives sync_n, data_i, cm_rom_n)
//   modport slave  : the ROM slot controller
// ---------------------------------------------------------------------------
interface mcs4_rom_bus_ctrl_if;
  logic       sync_n;
  logic [3:0] data_i;
  logic       cm_rom_n;
  logic [3:0] data_o;
  logic       data_oe;

  modport master (
    output sync_n,
    output data_i,
    output cm_rom_n,
    input  data_o,
    input  data_oe
  );

  modport slave (
    input  sync_n,
    input  data_i,
    input  cm_rom_n,
    output data_o,
    output data_oe
  );
endinterface

// File: rtl/mcs4_rom_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mcs4_rom_bus_ctrl
//   Bus-side controller for one i4001-style ROM slot on the MCS-4 4-bit bus.
//   Locks onto the CPU's SYNC_N, tracks the 8-phase instruction cycle
//   (A1 A2 A3 M1 M2 X1 X2 X3 = phases 0..7), captures the 12-bit address,
//   selects on the chip number in A3 and runs a one-cycle synchronous ROM
//   read. The fetched opcode is returned on DATA during M1 (high nibble)
//   and M2 (low nibble).
//
// Parameters
//   CHIP_ID   chip number matched against the A3 address nibble
//
// Ports
//   clk       in   system clock
//   res       in   synchronous reset, active-high
//   bus       slave modport of mcs4_rom_bus_ctrl_if (SYNC_N, DATA, CM_ROM_N)
//   rom_addr  out  memory address {A2,A1}
//   rom_rd    out  memory read strobe, high for the whole A3 cycle
//   rom_data  in   memory data, valid the cycle after rom_rd
//   phase     out  current phase 0..7, 0 while unlocked
//   locked    out  phase tracker locked to SYNC_N
//   io_out    out  4-bit output port (only with MCS4_ROM_IO_PORT_EN)
//   io_in     in   4-bit input port  (only with MCS4_ROM_IO_PORT_EN)
//
// Configuration
//   MCS4_ROM_IO_PORT_EN  when defined, adds the ROM I/O port together with
//                        SRC decoding and the WRR / RDR instructions.
// ---------------------------------------------------------------------------
module mcs4_rom_bus_ctrl #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic                 clk,
  input  logic                 res,
  mcs4_rom_bus_ctrl_if.slave   bus,
  output logic [7:0]           rom_addr,
  output logic                 rom_rd,
  input  logic [7:0]           rom_data,
  output logic [2:0]           phase,
  output logic                 locked
`ifdef MCS4_ROM_IO_PORT_EN
  ,
  output logic [3:0]           io_out,
  input  logic [3:0]           io_in
`endif
);

  // Phase numbers of the instruction cycle.
  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] phase_next;

  // step:  a normal advance out of phases A1..X2; every capture into the
  //        instruction-cycle registers is qualified by it.
  // abort: resync or lost lock, which kills the cycle in flight.
  logic       step;
  logic       abort;

  logic       sel;
  logic [3:0] op_lo;

`ifdef MCS4_ROM_IO_PORT_EN
  logic [3:0] opr;
  logic       src_hit;
  logic       io_wrr;
  logic       io_rdr;
`endif

  // The phase tracker: state and phase register. While unlocked the phase
  // register simply stays at zero.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_UNSYNC;
      phase <= 3'd0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // Next-state logic and outputs of the phase tracker. SYNC_N low is always
  // a request to restart at A1: in X3 that is the normal wrap, in any other
  // phase it is a resync that throws away the current cycle. A missing
  // SYNC_N in X3 means the CPU is no longer where we think it is, so lock
  // is dropped and the bus is released.
  always_comb begin
    state_next = state;
    phase_next = phase;
    step       = 1'b0;
    abort      = 1'b0;
    locked     = 1'b0;
    rom_rd     = 1'b0;
    bus.data_o  = 4'h0;
    bus.data_oe = 1'b0;

    case (state)
      ST_UNSYNC: begin
        phase_next = 3'd0;
        if (!bus.sync_n) begin
          state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        locked = 1'b1;
        if (!bus.sync_n) begin
          phase_next = 3'd0;
          abort      = (phase != PH_X3);
        end else if (phase == PH_X3) begin
          state_next = ST_UNSYNC;
          phase_next = 3'd0;
          abort      = 1'b1;
        end else begin
          phase_next = phase + 3'd1;
          step       = 1'b1;
        end
      end
      default: begin
        state_next = ST_UNSYNC;
        phase_next = 3'd0;
      end
    endcase

    // The read goes out in A3 whether or not this chip ends up selected,
    // because the chip number only arrives at the end of A3.
    if (locked && phase == PH_A3) begin
      rom_rd = 1'b1;
    end

    // The high nibble comes straight from the memory output so that it is
    // on the bus in M1; the low nibble is replayed from op_lo in M2.
    if (locked && sel && phase == PH_M1) begin
      bus.data_o  = rom_data[7:4];
      bus.data_oe = 1'b1;
    end else if (locked && sel && phase == PH_M2) begin
      bus.data_o  = op_lo;
      bus.data_oe = 1'b1;
    end
`ifdef MCS4_ROM_IO_PORT_EN
    else if (locked && io_rdr && phase == PH_X2) begin
      bus.data_o  = io_in;
      bus.data_oe = 1'b1;
    end
`endif
  end

  // Instruction-cycle datapath: address nibbles in A1/A2, chip select in
  // A3, low opcode nibble in M1. The select lives only from the end of A3
  // to the end of M2, and any abort drops it immediately.
  always_ff @(posedge clk) begin
    if (res) begin
      rom_addr <= 8'h00;
      sel      <= 1'b0;
      op_lo    <= 4'h0;
    end else if (abort) begin
      sel <= 1'b0;
    end else if (step) begin
      case (phase)
        PH_A1: rom_addr[3:0] <= bus.data_i;
        PH_A2: rom_addr[7:4] <= bus.data_i;
        PH_A3: sel           <= (bus.data_i == CHIP_ID) && !bus.cm_rom_n;
        PH_M1: op_lo         <= rom_data[3:0];
        PH_M2: sel           <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MCS4_ROM_IO_PORT_EN
  // I/O port sequencing. SRC is recognised by CM_ROM_N low at X2, and its
  // X2 nibble decides whether this chip is the target of the following
  // I/O instructions; that verdict is kept until the next SRC. An I/O
  // instruction is one whose opcode this chip supplied with OPR = 0xE and
  // with CM_ROM_N asserted in M2. The opcode comes from our own memory, so
  // OPR/OPA are taken from ROM_DATA rather than from the bus. The WRR/RDR
  // decision is registered at the end of M2 and consumed in X2.
  always_ff @(posedge clk) begin
    if (res) begin
      opr     <= 4'h0;
      src_hit <= 1'b0;
      io_wrr  <= 1'b0;
      io_rdr  <= 1'b0;
      io_out  <= 4'h0;
    end else if (abort) begin
      io_wrr <= 1'b0;
      io_rdr <= 1'b0;
    end else if (step) begin
      case (phase)
        PH_M1: begin
          if (sel) begin
            opr <= rom_data[7:4];
          end
        end
        PH_M2: begin
          io_wrr <= sel && (opr == 4'hE) && !bus.cm_rom_n && src_hit && (op_lo == 4'h2);
          io_rdr <= sel && (opr == 4'hE) && !bus.cm_rom_n && src_hit && (op_lo == 4'hA);
        end
        PH_X2: begin
          if (io_wrr) begin
            io_out <= bus.data_i;
          end
          if (!bus.cm_rom_n) begin
            src_hit <= (bus.data_i == CHIP_ID);
          end
          io_wrr <= 1'b0;
          io_rdr <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mcs4_rom_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcs4_rom_bus_ctrl
//   Self-checking bench for mcs4_rom_bus_ctrl (CHIP_ID = 0). A behavioural
//   model of the ROM slot, written in terms of instruction-cycle phases and
//   the fetched memory byte, predicts every output each cycle. Directed
//   instruction cycles come first, followed by a randomized CPU with
//   occasional sync glitches, missing syncs and resets. With
//   MCS4_ROM_IO_PORT_EN defined the model also covers SRC/WRR/RDR.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mcs4_rom_bus_ctrl;

  localparam logic [3:0] CHIP = 4'h0;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] rom_addr;
  logic       rom_rd;
  logic [7:0] rom_data = 8'h00;
  logic [2:0] phase;
  logic       locked;
  logic [7:0] mem [256];

  mcs4_rom_bus_ctrl_if bus ();

`ifdef MCS4_ROM_IO_PORT_EN
  logic [3:0] io_out;
  logic [3:0] io_in;
`endif

  mcs4_rom_bus_ctrl #(.CHIP_ID(CHIP)) dut (
    .clk      (clk),
    .res      (res),
    .bus      (bus.slave),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .rom_data (rom_data),
    .phase    (phase),
    .locked   (locked)
`ifdef MCS4_ROM_IO_PORT_EN
    ,
    .io_out   (io_out),
    .io_in    (io_in)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory: data shows up the cycle after the read strobe.
  always @(posedge clk) begin
    if (rom_rd) rom_data <= mem[rom_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_locked, m_phase, m_addr, m_sel;
`ifdef MCS4_ROM_IO_PORT_EN
  int m_src_hit, m_wrr, m_rdr, m_io_out;
`endif

  bit rand_io = 1'b1;

  // Outputs seen at the most recent check and per phase of run_cycle.
  logic [3:0] last_do;
  logic       last_oe, last_rd, last_locked;
  logic [2:0] last_phase;
  logic [7:0] last_addr;
  logic [3:0] obs_do [8];
  logic       obs_oe [8];
  logic       obs_rd [8];
  logic       obs_locked [8];
  logic [2:0] obs_phase [8];
  logic [7:0] obs_addr [8];

  int         g_phase;
  bit         g_r, g_s, g_c;
  logic [3:0] g_d;
  int         oe_count;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_phase = 0; m_addr = 0; m_sel = 0;
`ifdef MCS4_ROM_IO_PORT_EN
    m_src_hit = 0; m_wrr = 0; m_rdr = 0; m_io_out = 0;
`endif
  endtask

  // Expected outputs follow from the phase and from the memory byte at the
  // captured address: high nibble in M1, low nibble in M2, if selected.
  task automatic check_all();
    logic [7:0] b;
    int e_oe, e_do;
    b = mem[m_addr];
    e_oe = 0;
    e_do = 0;
    if (m_locked != 0 && m_sel != 0 && m_phase == 3) begin e_oe = 1; e_do = int'(b[7:4]); end
    if (m_locked != 0 && m_sel != 0 && m_phase == 4) begin e_oe = 1; e_do = int'(b[3:0]); end
`ifdef MCS4_ROM_IO_PORT_EN
    if (m_locked != 0 && m_rdr != 0 && m_phase == 6) begin e_oe = 1; e_do = int'(io_in); end
    checkOutput("io_out", io_out, m_io_out);
`endif
    checkOutput("phase", phase, m_phase);
    checkOutput("locked", locked, m_locked);
    checkOutput("rom_rd", rom_rd, (m_locked != 0 && m_phase == 2));
    checkOutput("rom_addr", rom_addr, m_addr);
    checkOutput("data_oe", bus.data_oe, e_oe);
    checkOutput("data_o", bus.data_o, e_do);
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_update(input bit r, input bit s, input logic [3:0] d, input bit c);
    logic [7:0] b;
    b = mem[m_addr];
    if (r) begin
      model_reset();
    end else if (m_locked == 0) begin
      if (!s) begin m_locked = 1; m_phase = 0; end
    end else if (!s || m_phase == 7) begin
      if (s) m_locked = 0;
      m_phase = 0;
      m_sel   = 0;
`ifdef MCS4_ROM_IO_PORT_EN
      m_wrr = 0; m_rdr = 0;
`endif
    end else begin
      case (m_phase)
        0: m_addr = (m_addr & 'hF0) | int'(d);
        1: m_addr = (m_addr & 'h0F) | (int'(d) * 16);
        2: m_sel  = (d == CHIP && !c) ? 1 : 0;
        4: begin
`ifdef MCS4_ROM_IO_PORT_EN
          if (m_sel != 0 && b[7:4] == 4'hE && !c && m_src_hit != 0) begin
            m_wrr = (b[3:0] == 4'h2) ? 1 : 0;
            m_rdr = (b[3:0] == 4'hA) ? 1 : 0;
          end
`endif
          m_sel = 0;
        end
`ifdef MCS4_ROM_IO_PORT_EN
        6: begin
          if (m_wrr != 0) m_io_out = int'(d);
          if (!c) m_src_hit = (d == CHIP) ? 1 : 0;
          m_wrr = 0; m_rdr = 0;
        end
`endif
        default: ;
      endcase
      m_phase++;
    end
  endtask

  // One clock: check the current outputs, drive the next inputs, and move
  // the model across the coming edge.
  task automatic applyStimulus(input bit r, input bit s, input logic [3:0] d, input bit c);
    @(negedge clk);
    check_all();
    last_do = bus.data_o; last_oe = bus.data_oe; last_rd = rom_rd;
    last_locked = locked; last_phase = phase; last_addr = rom_addr;
    res = r;
    bus.sync_n = s;
    bus.data_i = d;
    bus.cm_rom_n = c;
`ifdef MCS4_ROM_IO_PORT_EN
    if (rand_io) io_in = 4'($urandom_range(15, 0));
`endif
    model_update(r, s, d, c);
  endtask

  // One well-formed instruction cycle starting at A1; SYNC_N low in X3.
  task automatic run_cycle(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                           input bit c_a3, input bit c_m2, input logic [3:0] x2, input bit c_x2);
    for (int ph = 0; ph < 8; ph++) begin
      logic [3:0] d;
      bit c;
      d = 4'($urandom_range(15, 0));
      c = 1'b1;
      case (ph)
        0: d = a0;
        1: d = a1;
        2: begin d = a2; c = c_a3; end
        4: c = c_m2;
        6: begin d = x2; c = c_x2; end
        default: ;
      endcase
      applyStimulus(1'b0, (ph != 7), d, c);
      obs_do[ph] = last_do; obs_oe[ph] = last_oe; obs_rd[ph] = last_rd;
      obs_locked[ph] = last_locked; obs_phase[ph] = last_phase; obs_addr[ph] = last_addr;
    end
  endtask

  function automatic int count_oe();
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (obs_oe[i]) n++;
    return n;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(255, 0));
    mem[8'h35] = 8'hD7;
    mem[8'h40] = 8'hE2;
    mem[8'h41] = 8'hEA;

    res = 1'b1;
    bus.sync_n = 1'b1;
    bus.data_i = 4'h0;
    bus.cm_rom_n = 1'b1;
`ifdef MCS4_ROM_IO_PORT_EN
    io_in = 4'h0;
`endif
    model_reset();

    // Reset, then idle without sync.
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
    checkOutput("reset_locked", last_locked, 1'b0);
    checkOutput("reset_addr", last_addr, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);

    // First SYNC_N, then a cycle for a different chip.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    run_cycle(4'h0, 4'h0, 4'h1, 1'b1, 1'b1, 4'h0, 1'b1);
    checkOutput("lock_first_a1", obs_locked[0], 1'b1);
    checkOutput("phase_x3", obs_phase[7], 3'd7);

    // Fetch from 0x035 (ROM[0x35] = 0xD7).
    run_cycle(4'h5, 4'h3, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1);
    checkOutput("fetch_rd_a3", obs_rd[2], 1'b1);
    checkOutput("fetch_addr_a3", obs_addr[2], 8'h35);
    checkOutput("fetch_m1", obs_do[3], 4'hD);
    checkOutput("fetch_m2", obs_do[4], 4'h7);
    checkOutput("fetch_oe_count", count_oe(), 2);

    // Wrong chip number, then CM_ROM_N high in A3.
    run_cycle(4'h5, 4'h3, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1);
    checkOutput("wrong_chip_oe", count_oe(), 0);
    run_cycle(4'h5, 4'h3, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    checkOutput("cm_high_oe", count_oe(), 0);

    // Resync with SYNC_N low in M2.
    applyStimulus(1'b0, 1'b1, 4'h5, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h3, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
    checkOutput("resync_phase", last_phase, 3'd0);
    checkOutput("resync_oe", last_oe, 1'b0);

    // Missing SYNC_N at X3.
    for (int ph = 1; ph < 8; ph++) applyStimulus(1'b0, 1'b1, 4'($urandom_range(15, 0)), 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
    checkOutput("lost_lock", last_locked, 1'b0);
    checkOutput("lost_phase", last_phase, 3'd0);

    // Reset during M1 of a selected cycle.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h5, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h3, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b1);
    checkOutput("m1_before_reset", last_oe, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
    checkOutput("reset_m1_oe", last_oe, 1'b0);
    checkOutput("reset_m1_locked", last_locked, 1'b0);
    checkOutput("reset_m1_addr", last_addr, 8'h00);

    // Randomized CPU with occasional glitches and resets.
    g_phase = 0;
    for (int i = 0; i < 4000; i++) begin
      g_r = ($urandom_range(499, 0) == 0);
      g_s = (g_phase != 7);
      if ($urandom_range(63, 0) == 0) g_s = ~g_s;
      g_d = 4'($urandom_range(15, 0));
      if (g_phase == 2 && $urandom_range(3, 0) != 0) g_d = CHIP;
      if (g_phase == 6 && $urandom_range(1, 0) == 0) g_d = CHIP;
      g_c = ($urandom_range(3, 0) == 0);
      applyStimulus(g_r, g_s, g_d, g_c);
      g_phase = (!g_s) ? 0 : (g_phase + 1) % 8;
    end

`ifdef MCS4_ROM_IO_PORT_EN
    // SRC to this chip, WRR 0xA, then RDR with IO_IN = 6.
    rand_io = 1'b0;
    io_in = 4'h6;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    run_cycle(4'h0, 4'h0, 4'h1, 1'b1, 1'b1, 4'h0, 1'b0);
    run_cycle(4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1);
    checkOutput("wrr_io_out", io_out, 4'hA);
    run_cycle(4'h1, 4'h4, 4'h0, 1'b0, 1'b0, 4'h3, 1'b1);
    checkOutput("rdr_data", obs_do[6], 4'h6);
    checkOutput("rdr_oe", obs_oe[6], 1'b1);
`endif

    applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
